// File: rtl/inst_loader_if.sv
`timescale 1ns/1ps
// Byte-stream ingress plus instruction-memory write port of the boot loader.
// Latency: none (wires only).
// Backpressure: byteReady from the loader gates byteValid/byteData from the source.
//
// Ports: byteValid/byteData/byteReady = host byte stream handshake;
//        memAddress/memWriteData/memWrite = instruction memory write port.
// Modports: master = the loader (drives memory port, consumes bytes);
//           slave  = the surrounding system (byte source, memory sink).
interface inst_loader_if;
    logic        byteValid;
    logic [7:0]  byteData;
    logic        byteReady;
    logic [31:0] memAddress;
    logic [31:0] memWriteData;
    logic        memWrite;

    modport master (
        input  byteValid, byteData,
        output byteReady, memAddress, memWriteData, memWrite
    );

    modport slave (
        output byteValid, byteData,
        input  byteReady, memAddress, memWriteData, memWrite
    );
endinterface

// File: rtl/inst_loader.sv
`timescale 1ns/1ps
// Boot-time instruction memory writer: packs big-endian words from a byte stream and holds the CPU in reset until loaded.
// Latency: 4 accepted bytes + 1 write cycle per word; done one cycle after the last write (or after start when count is 0).
// Backpressure: byteReady high only while receiving; byteValid stalls hold state forever, bytes offered elsewhere are not consumed.
//
// Ports: clk, reset (async active-low); start/loadCount begin a load (ignored while busy);
//        bus = byte stream in + memory write port out; busy/done/cpuReset status;
//        checksum = XOR of every word written by the current/last load.
module inst_loader #(
    parameter int DEPTH = 64,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] loadCount,
    inst_loader_if.master    bus,
    output logic             busy,
    output logic             done,
    output logic             cpuReset,
    output logic [31:0]      checksum
);

    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    state_t           state;
    state_t           next_state;
    logic [1:0]       byte_cnt;
    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] clamped;
    logic             start_ok;
    logic             byte_take;
    logic             last_word;

    // memAddress doubles as the word counter: it always equals the number
    // of words already written in this load.
    always_comb begin
        start_ok   = start && ((state == IDLE) || (state == DONE));
        clamped    = (loadCount > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : loadCount;
        byte_take  = (state == RECV) && bus.byteValid && bus.byteReady;
        last_word  = ((bus.memAddress + 32'd1) == 32'(target));
        next_state = state;
        case (state)
            IDLE, DONE: begin
                if (start_ok) begin
                    next_state = (clamped == '0) ? DONE : RECV;
                end
            end
            RECV: begin
                if (byte_take && (byte_cnt == 2'd3)) begin
                    next_state = WRITE;
                end
            end
            WRITE: begin
                next_state = last_word ? DONE : RECV;
            end
            default: next_state = IDLE;
        endcase
    end

    // Status outputs are registered from next_state so they line up with
    // the state they describe in the cycle after each edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            byte_cnt         <= '0;
            target           <= '0;
            bus.byteReady    <= 1'b0;
            bus.memWrite     <= 1'b0;
            bus.memAddress   <= '0;
            bus.memWriteData <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            cpuReset         <= 1'b1;
            checksum         <= '0;
        end else begin
            state         <= next_state;
            bus.byteReady <= (next_state == RECV);
            bus.memWrite  <= (next_state == WRITE);
            busy          <= (next_state == RECV) || (next_state == WRITE);
            done          <= (next_state == DONE);
            cpuReset      <= (next_state != DONE);

            if (start_ok) begin
                target         <= clamped;
                bus.memAddress <= '0;
                checksum       <= '0;
                byte_cnt       <= '0;
            end

            // Shifting left four times puts byte 0 in [31:24]; the word is
            // complete exactly when the WRITE cycle presents it.
            if (byte_take) begin
                bus.memWriteData <= {bus.memWriteData[23:0], bus.byteData};
                byte_cnt         <= byte_cnt + 2'd1;
            end

            if (state == WRITE) begin
                checksum       <= checksum ^ bus.memWriteData;
                bus.memAddress <= bus.memAddress + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
`timescale 1ns/1ps
module tb_inst_loader;

    localparam int DEPTH = 64;
    localparam int CNT_W = 7;

    logic             clk;
    logic             reset;
    logic             start;
    logic [CNT_W-1:0] loadCount;
    logic             busy;
    logic             done;
    logic             cpuReset;
    logic [31:0]      checksum;

    inst_loader_if bus ();

    inst_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .loadCount (loadCount),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .cpuReset  (cpuReset),
        .checksum  (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Behavioural memory plus observation of the write port and byte handshake.
    logic [31:0] mem [0:DEPTH-1];
    logic [31:0] wr_addr [$];
    logic [31:0] wr_data [$];
    logic [7:0]  stim [$];
    int          bytes_seen = 0;
    int          back2back  = 0;
    logic        prev_wr    = 1'b0;

    always @(negedge clk) begin
        if (bus.memWrite === 1'b1) begin
            wr_addr.push_back(bus.memAddress);
            wr_data.push_back(bus.memWriteData);
            mem[bus.memAddress[5:0]] = bus.memWriteData;
            if (prev_wr) back2back++;
        end
        prev_wr = (bus.memWrite === 1'b1);
        if (bus.byteValid && bus.byteReady) bytes_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_obs();
        wr_addr.delete();
        wr_data.delete();
        bytes_seen = 0;
        back2back  = 0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
    endtask

    // mode 0: byteValid held high, 1: toggles every cycle, 2: random
    task automatic do_load(input string name, input int cnt, input int mode, input bit pulse_mid);
        int          nw;
        int          nb;
        int          idx;
        int          budget;
        bit          acc;
        bit          tog;
        logic [31:0] w;
        logic [31:0] csum;
        nw = (cnt > DEPTH) ? DEPTH : cnt;
        nb = 4 * nw;
        while (stim.size() < nb) stim.push_back(8'($urandom_range(0, 255)));
        clear_obs();

        start     = 1'b1;
        loadCount = CNT_W'(cnt);
        @(posedge clk); #1;
        start = 1'b0;
        if (nw == 0)
            check({name, "_start_status"}, 32'({done, busy, cpuReset, bus.byteReady}), 32'b1000);
        else
            check({name, "_start_status"}, 32'({done, busy, cpuReset, bus.byteReady}), 32'b0111);

        idx    = 0;
        budget = 0;
        tog    = 1'b0;
        while (idx < nb && budget < 3000) begin
            case (mode)
                0:       bus.byteValid = 1'b1;
                1:       begin bus.byteValid = tog; tog = !tog; end
                default: bus.byteValid = 1'($urandom_range(0, 1));
            endcase
            bus.byteData = stim[idx];
            if (pulse_mid && idx == 5) begin
                start     = 1'b1;
                loadCount = CNT_W'(9);
            end else begin
                start = 1'b0;
            end
            acc = bus.byteValid && bus.byteReady;
            @(posedge clk); #1;
            budget++;
            if (acc) idx++;
        end
        bus.byteValid = 1'b0;
        start         = 1'b0;
        check({name, "_bytes_fed"}, idx, nb);

        budget = 0;
        while (done !== 1'b1 && budget < 100) begin
            @(posedge clk); #1;
            budget++;
        end
        check({name, "_end_status"}, 32'({done, busy, cpuReset, bus.byteReady, bus.memWrite}), 32'b10000);
        check({name, "_bytes_consumed"}, bytes_seen, nb);
        check({name, "_write_count"}, wr_addr.size(), nw);
        check({name, "_back2back_writes"}, back2back, 0);

        csum = 32'h0;
        for (int i = 0; i < nw; i++) begin
            w = (32'(stim[4*i]) << 24) | (32'(stim[4*i+1]) << 16) |
                (32'(stim[4*i+2]) << 8) | 32'(stim[4*i+3]);
            csum = csum ^ w;
            if (i < wr_addr.size()) begin
                check({name, "_addr"}, wr_addr[i], i);
                check({name, "_data"}, wr_data[i], w);
            end
            check({name, "_readback"}, mem[i], w);
        end
        check({name, "_checksum"}, checksum, csum);
        check({name, "_final_addr"}, bus.memAddress, nw);
        stim.delete();
    endtask

    initial begin
        int idx;
        int budget;
        bit acc;

        reset         = 1'b1;
        start         = 1'b0;
        loadCount     = '0;
        bus.byteValid = 1'b0;
        bus.byteData  = 8'h00;
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Idle after reset: CPU held, nothing moving.
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            check("idle_after_reset", 32'({cpuReset, busy, done, bus.byteReady, bus.memWrite}), 32'b10000);
        end

        // Directed two-word load, back-to-back bytes.
        stim = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hAB, 8'hCD, 8'hEF, 8'h01};
        do_load("two_words", 2, 0, 1'b0);
        check("two_words_checksum_const", checksum, 32'hB9F9B979);
        check("two_words_mem0_const", mem[0], 32'h12345678);
        check("two_words_mem1_const", mem[1], 32'hABCDEF01);

        do_load("toggle_valid", 3, 1, 1'b0);
        do_load("zero_count", 0, 0, 1'b0);
        do_load("clamp_100", 100, 2, 1'b0);
        check("clamp_last_addr", (wr_addr.size() > 0) ? wr_addr[wr_addr.size()-1] : 32'hFFFF_FFFF, 32'd63);
        do_load("start_during_recv", 2, 0, 1'b1);
        do_load("random_load", 1 + int'($urandom_range(0, 7)), 2, 1'b0);

        // Reset in the middle of word 0 after two bytes.
        for (int i = 0; i < 8; i++) stim.push_back(8'($urandom_range(0, 255)));
        clear_obs();
        start     = 1'b1;
        loadCount = CNT_W'(2);
        @(posedge clk); #1;
        start         = 1'b0;
        idx           = 0;
        budget        = 0;
        bus.byteValid = 1'b1;
        while (idx < 2 && budget < 100) begin
            bus.byteData = stim[idx];
            acc = bus.byteValid && bus.byteReady;
            @(posedge clk); #1;
            budget++;
            if (acc) idx++;
        end
        check("midreset_bytes_fed", idx, 2);
        reset = 1'b0;
        #1;
        check("midreset_status", 32'({cpuReset, busy, done, bus.byteReady, bus.memWrite}), 32'b10000);
        check("midreset_addr", bus.memAddress, 32'h0);
        check("midreset_checksum", checksum, 32'h0);
        check("midreset_wdata", bus.memWriteData, 32'h0);
        bus.byteValid = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        check("midreset_no_write", wr_addr.size(), 0);
        check("midreset_cpu_held", 32'(cpuReset), 32'd1);
        stim.delete();
        do_load("after_reset", 1, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
